// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program RAM plus PC walker that issues one instruction per
// core window, with a one-cycle newinstr strobe and busy/done status.
module instr_issue_unit #(
    parameter int          DEPTH            = 64,
    parameter int          ADDR_W           = 6,
    parameter int          CYCLES_PER_INSTR = 4,
    parameter logic [31:0] HALT_WORD        = 32'hFFFFFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              hold,
    output logic [31:0]       instrword,
    output logic              newinstr,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(CYCLES_PER_INSTR + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CYCLES_PER_INSTR);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_n;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       instr_n, rd;
    logic              new_n, busy_n, done_n, idle_like, last;
    logic [ADDR_W-1:0] pc_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [LEN_W-1:0]  len, len_n, clamped;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign rd        = mem[pc];
    assign clamped   = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign last      = ({1'b0, pc} == len - 1'b1);

    // RAM contents survive reset; writes only land while idle
    always_ff @(posedge clock) begin
        if (load_en && idle_like) mem[load_addr] <= load_data;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instrword;
        new_n   = 1'b0;
        busy_n  = busy;
        done_n  = done;
        cnt_n   = cnt;
        len_n   = len;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    len_n   = clamped;
                    pc_n    = '0;
                    state_n = (clamped == '0) ? DONE : ISSUE;
                    busy_n  = (clamped != '0);
                    done_n  = (clamped == '0);
                end
            end
            ISSUE: begin
                if (rd == HALT_WORD) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    instr_n = rd;
                    new_n   = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // the window closes on the edge after the counter has reached zero
                if (!hold) begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else if (last) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        pc_n    = pc + 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            instrword <= '0;
            newinstr  <= 1'b0;
            pc        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            len       <= '0;
        end else begin
            state     <= state_n;
            instrword <= instr_n;
            newinstr  <= new_n;
            pc        <= pc_n;
            busy      <= busy_n;
            done      <= done_n;
            cnt       <= cnt_n;
            len       <= len_n;
        end
    end
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: directed vectors for the instruction issue unit.
module tb_instr_issue_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [5:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic [6:0]  prog_len = '0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] instrword;
    logic        newinstr;
    logic [5:0]  pc;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    instr_issue_unit dut (
        .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .hold(hold),
        .instrword(instrword), .newinstr(newinstr), .pc(pc), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] word;
        logic [5:0]  pc;
        int          gap;
    } issue_vec_t;

    typedef struct {
        logic [6:0] plen;
        int         strobes;
    } len_vec_t;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] plen);
        prog_len = plen;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_strobe(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (newinstr) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max, output int n, output int s);
        n = -1;
        s = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (newinstr) s++;
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    issue_vec_t iv [3];
    len_vec_t   lv [4];
    int n, s;
    logic [31:0] held;

    initial begin
        iv[0] = '{32'h20080005, 6'd0, 1};
        iv[1] = '{32'h20090003, 6'd1, 6};
        iv[2] = '{32'h01095020, 6'd2, 6};
        lv[0] = '{7'd1, 1};
        lv[1] = '{7'd3, 3};
        lv[2] = '{7'd64, 64};
        lv[3] = '{7'd69, 64};

        #12;
        chk("rst_instr", instrword, 32'h0);
        chk("rst_flags", {28'h0, newinstr, busy, done, 1'b0}, 32'h0);
        chk("rst_pc", {26'h0, pc}, 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) load(6'(i), iv[i].word);
        do_start(7'd3);
        chk("start_busy", {30'h0, busy, done}, 32'h2);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(20, n);
            chk($sformatf("gap%0d", i), n, iv[i].gap);
            chk($sformatf("word%0d", i), instrword, iv[i].word);
            chk($sformatf("pc%0d", i), {26'h0, pc}, {26'h0, iv[i].pc});
        end
        wait_done(20, n, s);
        chk("run_done_lat", n, 5);
        chk("run_done_flags", {30'h0, busy, done}, 32'h1);
        chk("run_done_word", instrword, 32'h01095020);

        do_start(7'd3);
        wait_strobe(20, n);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_word", instrword, 32'h20080005);
        end
        hold = 1'b0;
        wait_strobe(20, n);
        chk("hold_gap", n + 3, 9);
        chk("hold_word2", instrword, 32'h20090003);
        wait_done(40, n, s);
        chk("hold_done", {31'h0, done}, 32'h1);

        do_start(7'd3);
        wait_strobe(20, n);
        start = 1'b1;
        load_en = 1'b1;
        load_addr = 6'd1;
        load_data = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        load_en = 1'b0;
        chk("ign_busy", {30'h0, busy, newinstr}, 32'h2);
        wait_strobe(20, n);
        chk("ign_gap", n, 5);
        chk("ign_pc", {26'h0, pc}, 32'h1);
        wait_done(40, n, s);
        chk("ign_tail", n, 11);
        chk("ign_strobes", s, 1);
        do_start(7'd3);
        wait_strobe(20, n);
        wait_strobe(20, n);
        chk("ign_ram1", instrword, 32'h20090003);
        wait_done(40, n, s);

        load(6'd1, 32'hFFFFFFFF);
        do_start(7'd5);
        wait_strobe(20, n);
        chk("halt_first", instrword, 32'h20080005);
        wait_done(20, n, s);
        chk("halt_lat", n, 6);
        chk("halt_strobes", s, 0);
        chk("halt_flags", {29'h0, busy, done, newinstr}, 32'h2);
        chk("halt_word", instrword, 32'h20080005);
        chk("halt_pc", {26'h0, pc}, 32'h1);

        do_start(7'd3);
        wait_strobe(20, n);
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_word", instrword, 32'h0);
        chk("arst_flags", {28'h0, newinstr, busy, done, 1'b0}, 32'h0);
        chk("arst_pc", {26'h0, pc}, 32'h0);
        #3;
        reset = 1'b1;
        tick();
        do_start(7'd1);
        wait_strobe(20, n);
        chk("arst_ram0", instrword, 32'h20080005);
        wait_done(20, n, s);

        load_en = 1'b1;
        load_addr = 6'd0;
        load_data = 32'h22220000;
        do_start(7'd1);
        load_en = 1'b0;
        wait_strobe(20, n);
        chk("ldstart_gap", n, 1);
        chk("ldstart_word", instrword, 32'h22220000);
        wait_done(20, n, s);

        for (int i = 0; i < 64; i++) load(6'(i), 32'h10000000 + i);
        do_start(7'd0);
        chk("len0_flags", {29'h0, busy, done, newinstr}, 32'h2);
        tick();
        chk("len0_nostrobe", {31'h0, newinstr}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            do_start(lv[i].plen);
            wait_done(600, n, s);
            chk($sformatf("len%0d_strobes", lv[i].plen), s, lv[i].strobes);
            chk($sformatf("len%0d_lat", lv[i].plen), n, 6 * lv[i].strobes);
            chk($sformatf("len%0d_pc", lv[i].plen), {26'h0, pc}, lv[i].strobes - 1);
            chk($sformatf("len%0d_word", lv[i].plen), instrword, 32'h10000000 + lv[i].strobes - 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
